// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings, constants and helpers for the pipe_stage_reg register stage.
// Imported by both the slice register and the stage top.
package pipe_stage_reg_pkg;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] ZERO_WORD = '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } action_e;

  // Exactly one action per cycle; earlier tests take precedence.
  function automatic action_e decode_action(
    input logic rst_on,
    input logic flush_on,
    input logic stop_here,
    input logic stop_next
  );
    action_e act;
    if (rst_on)
      act = ACT_RESET;
    else if (flush_on)
      act = ACT_FLUSH;
    else if ((stop_here == STOP) && (stop_next == NO_STOP))
      act = ACT_BUBBLE;
    else if (stop_here == NO_STOP)
      act = ACT_ADVANCE;
    else
      act = ACT_HOLD;
    return act;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic             hit
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (hit && (cnt != CNT_MAX))
      nxt = cnt + CNT_W'(1);
    return nxt;
  endfunction

  function automatic logic [2:0] count_valid(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++)
      n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slice.sv
// One valid+data register slice with clear/load/hold controls.
// Clear wins over load; an invalid slice always stores zero data.
module pipe_slice
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load) begin
      valid_d = in_valid;
      data_d  = in_valid ? in_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Stall/flush-aware pipeline register of DEPTH slices with occupancy and
// optional saturating event counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int PERF    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         occ,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  if ((DEPTH < 1) || (DEPTH > 4)) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end
  if (STAGE > STALL_W - 2) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be <= STALL_W-2");
  end

  action_e    action;
  logic       rst_on;
  logic       stop_here, stop_next;
  logic       slice_load, slice_clear;
  logic       head_valid;
  logic [WIDTH-1:0] head_data;
  logic       stall_unused;

  assign rst_on    = (rst == RST_ENABLE);
  assign stop_here = stall[STAGE];
  assign stop_next = stall[STAGE+1];
  // Only two stall bits matter to this stage; the rest are observed but ignored.
  assign stall_unused = ^stall;

  always_comb begin
    action = decode_action(rst_on, flush, stop_here, stop_next);
  end

  assign slice_clear = (action == ACT_RESET) || (action == ACT_FLUSH);
  assign slice_load  = (action == ACT_ADVANCE) || (action == ACT_BUBBLE);
  assign head_valid  = (action == ACT_ADVANCE) && in_valid;
  assign head_data   = head_valid ? in_data : '0;

  logic [DEPTH-1:0] slice_valid;
  logic [WIDTH-1:0] slice_data [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    logic             link_valid;
    logic [WIDTH-1:0] link_data;

    if (g == 0) begin : g_head
      assign link_valid = head_valid;
      assign link_data  = head_data;
    end else begin : g_chain
      assign link_valid = slice_valid[g-1];
      assign link_data  = slice_data[g-1];
    end

    pipe_slice #(
      .WIDTH (WIDTH)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .clear     (slice_clear),
      .load      (slice_load),
      .in_valid  (link_valid),
      .in_data   (link_data),
      .out_valid (slice_valid[g]),
      .out_data  (slice_data[g])
    );
  end

  assign out_valid = slice_valid[DEPTH-1];
  assign out_data  = slice_data[DEPTH-1];

  // Occupancy is computed from the slice valids as they will be after this edge.
  logic [DEPTH-1:0] valid_nx;
  logic [2:0]       occ_d, occ_q;

  always_comb begin
    valid_nx = slice_valid;
    if (slice_clear)
      valid_nx = '0;
    else if (slice_load)
      valid_nx = (slice_valid << 1) | DEPTH'(head_valid);
    occ_d = count_valid(4'(valid_nx));
  end

  always_ff @(posedge clk) begin
    if (rst_on)
      occ_q <= 3'd0;
    else
      occ_q <= occ_d;
  end

  assign occ = occ_q;

  if (PERF != 0) begin : g_perf
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d,   hold_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d,  flush_cnt_q;

    always_comb begin
      bubble_cnt_d = sat_inc(bubble_cnt_q, action == ACT_BUBBLE);
      hold_cnt_d   = sat_inc(hold_cnt_q,   action == ACT_HOLD);
      flush_cnt_d  = sat_inc(flush_cnt_q,  action == ACT_FLUSH);
    end

    always_ff @(posedge clk) begin
      if (rst_on) begin
        bubble_cnt_q <= ZERO_WORD;
        hold_cnt_q   <= ZERO_WORD;
        flush_cnt_q  <= ZERO_WORD;
      end else begin
        bubble_cnt_q <= bubble_cnt_d;
        hold_cnt_q   <= hold_cnt_d;
        flush_cnt_q  <= flush_cnt_d;
      end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
    assign flush_cnt  = flush_cnt_q;
  end else begin : g_no_perf
    assign bubble_cnt = ZERO_WORD;
    assign hold_cnt   = ZERO_WORD;
    assign flush_cnt  = ZERO_WORD;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: four pipe_stage_reg configurations share one stimulus
// stream and are compared every cycle against a slice-array reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic        in_valid;
  logic [31:0] in_data;

  logic        ov [4];
  logic [31:0] od [4];
  logic [2:0]  oc [4];
  logic [31:0] bc [4];
  logic [31:0] hc [4];
  logic [31:0] fc [4];

  int checks   = 0;
  int failures = 0;
  bit model_ready = 1'b0;

  always #5 clk = ~clk;

  // Instance k: 0 -> DEPTH1, 1 -> DEPTH3, 2 -> DEPTH2, 3 -> DEPTH4/STAGE2/no counters.
  pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .STALL_W(6), .STAGE(4), .PERF(1)) u_d1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .occ(oc[0]),
    .bubble_cnt(bc[0]), .hold_cnt(hc[0]), .flush_cnt(fc[0]));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .STALL_W(6), .STAGE(4), .PERF(1)) u_d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .occ(oc[1]),
    .bubble_cnt(bc[1]), .hold_cnt(hc[1]), .flush_cnt(fc[1]));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .STALL_W(6), .STAGE(4), .PERF(1)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .occ(oc[2]),
    .bubble_cnt(bc[2]), .hold_cnt(hc[2]), .flush_cnt(fc[2]));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(4), .STALL_W(6), .STAGE(2), .PERF(0)) u_d4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[3]), .out_data(od[3]), .occ(oc[3]),
    .bubble_cnt(bc[3]), .hold_cnt(hc[3]), .flush_cnt(fc[3]));

  function automatic int depth_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int stage_of(input int k);
    return (k == 3) ? 2 : 4;
  endfunction

  function automatic bit perf_of(input int k);
    return (k != 3);
  endfunction

  // Reference model: each instance is a plain array of (valid, data) slots.
  logic        mv [4][4];
  logic [31:0] md [4][4];
  logic [31:0] mb [4];
  logic [31:0] mh [4];
  logic [31:0] mf [4];

  always @(posedge clk) begin : model
    int  dep;
    bit  here, next;
    logic        new_v;
    logic [31:0] new_d;
    for (int k = 0; k < 4; k++) begin
      dep  = depth_of(k);
      here = stall[stage_of(k)];
      next = stall[stage_of(k) + 1];
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          mv[k][i] = 1'b0;
          md[k][i] = 32'h0;
        end
        mb[k] = 0; mh[k] = 0; mf[k] = 0;
      end else if (flush) begin
        for (int i = 0; i < 4; i++) begin
          mv[k][i] = 1'b0;
          md[k][i] = 32'h0;
        end
        if (mf[k] != 32'hFFFF_FFFF) mf[k] = mf[k] + 1;
      end else if (here && !next) begin
        for (int i = dep - 1; i > 0; i--) begin
          mv[k][i] = mv[k][i-1];
          md[k][i] = md[k][i-1];
        end
        mv[k][0] = 1'b0;
        md[k][0] = 32'h0;
        if (mb[k] != 32'hFFFF_FFFF) mb[k] = mb[k] + 1;
      end else if (!here) begin
        new_v = in_valid;
        new_d = in_valid ? in_data : 32'h0;
        for (int i = dep - 1; i > 0; i--) begin
          mv[k][i] = mv[k][i-1];
          md[k][i] = md[k][i-1];
        end
        mv[k][0] = new_v;
        md[k][0] = new_d;
      end else begin
        if (mh[k] != 32'hFFFF_FFFF) mh[k] = mh[k] + 1;
      end
    end
    if (rst) model_ready = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin : compare
    int dep;
    int cnt;
    if (model_ready) begin
      for (int k = 0; k < 4; k++) begin
        dep = depth_of(k);
        cnt = 0;
        for (int i = 0; i < dep; i++) cnt += int'(mv[k][i]);
        checkOutput($sformatf("d%0d out_valid", k), {31'h0, ov[k]}, {31'h0, mv[k][dep-1]});
        checkOutput($sformatf("d%0d out_data", k), od[k], md[k][dep-1]);
        checkOutput($sformatf("d%0d occ", k), {29'h0, oc[k]}, cnt);
        checkOutput($sformatf("d%0d bubble_cnt", k), bc[k], perf_of(k) ? mb[k] : 32'h0);
        checkOutput($sformatf("d%0d hold_cnt", k), hc[k], perf_of(k) ? mh[k] : 32'h0);
        checkOutput($sformatf("d%0d flush_cnt", k), fc[k], perf_of(k) ? mf[k] : 32'h0);
      end
    end
  end

  // Drives one cycle of inputs at a falling edge and returns at the next one.
  task automatic applyStimulus(input logic r, input logic f, input logic [5:0] s,
                               input logic v, input logic [31:0] d);
    rst      = r;
    flush    = f;
    stall    = s;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'h0; in_valid = 1'b0; in_data = 32'h0;
    @(negedge clk);

    applyStimulus(1, 0, 6'b000000, 0, 32'h0);
    checkOutput("reset d1 out_valid", {31'h0, ov[0]}, 32'h0);
    checkOutput("reset d3 occ", {29'h0, oc[1]}, 32'h0);
    checkOutput("reset d1 bubble_cnt", bc[0], 32'h0);

    applyStimulus(0, 0, 6'b000000, 1, 32'hDEAD_BEEF);
    checkOutput("adv d1 out_valid", {31'h0, ov[0]}, 32'h1);
    checkOutput("adv d1 out_data", od[0], 32'hDEAD_BEEF);
    checkOutput("adv d1 occ", {29'h0, oc[0]}, 32'h1);

    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_1234);
    applyStimulus(0, 0, 6'b010000, 1, 32'h0000_5555);
    checkOutput("bubble d1 out_valid", {31'h0, ov[0]}, 32'h0);
    checkOutput("bubble d1 out_data", od[0], 32'h0);
    checkOutput("bubble d1 bubble_cnt", bc[0], 32'h1);

    applyStimulus(1, 0, 6'b000000, 0, 32'h0);
    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 6'b110000, 1, 32'h0000_FFFF);
      checkOutput("hold d1 out_data", od[0], 32'h0000_1234);
    end
    checkOutput("hold d1 hold_cnt", hc[0], 32'h3);

    applyStimulus(1, 0, 6'b000000, 0, 32'h0);
    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_000A);
    applyStimulus(0, 0, 6'b010000, 1, 32'h0000_0077);
    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_000B);
    checkOutput("seq d3 cyc3 out_data", od[1], 32'h0000_000A);
    applyStimulus(0, 0, 6'b000000, 0, 32'h0);
    checkOutput("seq d3 cyc4 out_valid", {31'h0, ov[1]}, 32'h0);
    applyStimulus(0, 0, 6'b000000, 0, 32'h0);
    checkOutput("seq d3 cyc5 out_data", od[1], 32'h0000_000B);

    applyStimulus(1, 0, 6'b000000, 0, 32'h0);
    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_00A1);
    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_00B2);
    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_00C3);
    checkOutput("stream d3 occ", {29'h0, oc[1]}, 32'h3);
    applyStimulus(0, 1, 6'b110000, 1, 32'h0000_00D4);
    checkOutput("flush d3 occ", {29'h0, oc[1]}, 32'h0);
    checkOutput("flush d3 out_valid", {31'h0, ov[1]}, 32'h0);
    checkOutput("flush d3 flush_cnt", fc[1], 32'h1);

    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_0E01);
    applyStimulus(0, 0, 6'b000000, 1, 32'h0000_0E02);
    checkOutput("stream d2 occ", {29'h0, oc[2]}, 32'h2);
    applyStimulus(1, 1, 6'b110000, 1, 32'h0000_0E03);
    checkOutput("rstflush d2 out_valid", {31'h0, ov[2]}, 32'h0);
    checkOutput("rstflush d2 out_data", od[2], 32'h0);
    checkOutput("rstflush d2 occ", {29'h0, oc[2]}, 32'h0);
    checkOutput("rstflush d2 flush_cnt", fc[2], 32'h0);

    for (int n = 0; n < 800; n++) begin
      logic [5:0] s;
      for (int b = 0; b < 6; b++) s[b] = ($urandom_range(0, 2) == 0);
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 15) == 0), s,
                    ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits.
REQ-002 Parameter DEPTH, default 1, number of register slices, legal range 1..4.
REQ-003 Parameter STALL_W, default 6, width of the pipeline stall vector.
REQ-004 Parameter STAGE, default 4, index of this block's upstream stage in the stall vector; STAGE <= STALL_W-2, else elaboration error.
REQ-005 Parameter PERF, default 1, enables the performance counters.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 stall  in  STALL_W  pipeline stall vector, 1 = Stop, 0 = NoStop.
REQ-009 flush  in  1  discard all in-flight payload.
REQ-010 in_valid  in  1  upstream payload valid.
REQ-011 in_data  in  WIDTH  upstream payload.
REQ-012 out_valid  out  1  payload valid at the downstream side.
REQ-013 out_data  out  WIDTH  downstream payload.
REQ-014 occ  out  3  count of valid slices, 0..DEPTH.
REQ-015 bubble_cnt, hold_cnt, flush_cnt  out  32 each  event counters.

Function
REQ-016 Each cycle SHALL select exactly one action, in this priority order: rst, then flush, then BUBBLE (stall[STAGE]=1 and stall[STAGE+1]=0), then ADVANCE (stall[STAGE]=0), then HOLD (otherwise).
REQ-017 Flush SHALL clear every slice to valid=0 and data=0 at the next edge, regardless of stall.
REQ-018 ADVANCE SHALL load slice 0 with {in_valid, in_valid ? in_data : 0} and shift slice i-1 into slice i.
REQ-019 BUBBLE SHALL load slice 0 with {0, 0} and shift slice i-1 into slice i.
REQ-020 HOLD SHALL leave all slices unchanged.
REQ-021 in_valid/in_data presented during BUBBLE, HOLD or flush SHALL be dropped; the upstream stall contract guarantees it is not lost.
REQ-022 out_valid/out_data SHALL equal the last slice directly, with no combinational path from any input to any output.
REQ-023 An invalid slice SHALL always hold data=0.
REQ-024 Latency with no stall SHALL be DEPTH cycles; throughput SHALL be 1 payload/cycle.
REQ-025 occ SHALL be registered and SHALL equal the number of valid slices after every edge.
REQ-026 When PERF=1, each cycle with rst=0 SHALL increment bubble_cnt on BUBBLE, hold_cnt on HOLD and flush_cnt on flush.
REQ-027 Each counter SHALL saturate at 0xFFFF_FFFF and not wrap.
REQ-028 When PERF=0, all counters SHALL read constant 0 and no counter flops SHALL be built.
REQ-029 With DEPTH=1 and PERF=0, behaviour SHALL match a single stall/flush pipeline register exactly.

Reset
REQ-030 rst sampled high SHALL, at that edge, clear all slices to valid=0 and data=0, set occ=0 and clear all counters.
REQ-031 rst SHALL override flush and stall in the same cycle, including mid-stream.

Structure
REQ-032 Stall encodings (Stop/NoStop), RstEnable, ZeroWord and the counter width constant (32) SHALL live in the shared defines file.
REQ-033 One sub-module, pipe_slice (valid+data register with load/clear/hold controls), SHALL be instantiated DEPTH times via generate.
REQ-034 Action decode, occ and the counters SHALL reside in pipe_stage_reg.

Verification
REQ-035 DEPTH=1: stall=0, in_valid=1, in_data=0xDEADBEEF -> next cycle out_valid=1, out_data=0xDEADBEEF, occ=1.
REQ-036 DEPTH=1 holding 0x1234, stall=6'b010000 -> next cycle out_valid=0, out_data=0, bubble_cnt=1.
REQ-037 DEPTH=1 holding 0x1234, stall=6'b110000 for 3 cycles -> out_data stays 0x1234, hold_cnt=3, in_data ignored.
REQ-038 DEPTH=3 streaming A,B,C, then flush=1 together with stall=6'b110000 -> next cycle occ=0, out_valid=0, flush_cnt=1.
REQ-039 DEPTH=3: A, then one BUBBLE cycle, then B -> out shows A, invalid, B on cycles 3, 4, 5 after A entered.
REQ-040 DEPTH=2 mid-stream with rst=1 and flush=1 together -> next cycle all outputs 0, flush_cnt=0.
